// File: rtl/text_line_streamer.sv
// Line-to-ASCII byte streamer: looks up a line's ROM word range in the mapper,
// then emits each 16-bit ROM word as two bytes (high first) on a valid/ready stream.
module text_line_streamer #(
  parameter int ADDR_W = 10,
  parameter int LINE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [LINE_W-1:0]   req_line,
  output logic [LINE_W-1:0]   map_line,
  input  logic [2*ADDR_W-1:0] map_addr,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [15:0]         rom_dout,
  output logic                ch_valid,
  input  logic                ch_ready,
  output logic [7:0]          ch_data,
  output logic                ch_last,
  output logic                done,
  output logic                err
);

  // state  | meaning
  // IDLE   | accepting a line request
  // MAP1   | mapper registering its lookup of map_line
  // MAP2   | range capture and validity check
  // RD1    | ROM registering the word at rom_addr
  // RD2    | word latched, high byte presented
  // HI     | high byte on the stream, waiting for accept
  // LO     | low byte on the stream, waiting for accept
  typedef enum logic [2:0] {
    S_IDLE,
    S_MAP1,
    S_MAP2,
    S_RD1,
    S_RD2,
    S_HI,
    S_LO
  } state_t;

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   map_line_q, map_line_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [7:0]          lo_q, lo_d;
  logic [7:0]          ch_data_q, ch_data_d;
  logic                ch_valid_q, ch_valid_d;
  logic                ch_last_q, ch_last_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   map_start;
  logic [ADDR_W-1:0]   map_end;
  logic                at_end;

  assign map_start = map_addr[ADDR_W-1:0];
  assign map_end   = map_addr[2*ADDR_W-1:ADDR_W];
  assign at_end    = (rom_addr_q == end_q);

  always_comb begin
    state_d    = state_q;
    map_line_d = map_line_q;
    rom_addr_d = rom_addr_q;
    end_d      = end_q;
    lo_d       = lo_q;
    ch_data_d  = ch_data_q;
    ch_valid_d = ch_valid_q;
    ch_last_d  = ch_last_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          map_line_d = req_line;
          state_d    = S_MAP1;
        end
      end
      S_MAP1: state_d = S_MAP2;
      S_MAP2: begin
        end_d = map_end;
        // An inverted range never touches the ROM address.
        if (map_end < map_start) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          rom_addr_d = map_start;
          state_d    = S_RD1;
        end
      end
      S_RD1: state_d = S_RD2;
      S_RD2: begin
        lo_d       = rom_dout[7:0];
        ch_data_d  = rom_dout[15:8];
        ch_valid_d = 1'b1;
        ch_last_d  = 1'b0;
        state_d    = S_HI;
      end
      S_HI: begin
        if (ch_ready) begin
          ch_data_d = lo_q;
          ch_last_d = at_end;
          state_d   = S_LO;
        end
      end
      S_LO: begin
        if (ch_ready) begin
          ch_valid_d = 1'b0;
          ch_last_d  = 1'b0;
          // Increment only below end, so rom_addr cannot wrap at the top word.
          if (at_end) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = S_RD1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      map_line_q <= '0;
      rom_addr_q <= '0;
      end_q      <= '0;
      lo_q       <= '0;
      ch_data_q  <= '0;
      ch_valid_q <= 1'b0;
      ch_last_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      map_line_q <= map_line_d;
      rom_addr_q <= rom_addr_d;
      end_q      <= end_d;
      lo_q       <= lo_d;
      ch_data_q  <= ch_data_d;
      ch_valid_q <= ch_valid_d;
      ch_last_q  <= ch_last_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign map_line  = map_line_q;
  assign rom_addr  = rom_addr_q;
  assign ch_data   = ch_data_q;
  assign ch_valid  = ch_valid_q;
  assign ch_last   = ch_last_q;
  assign done      = done_q;
  assign err       = err_q;

  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (ch_valid && !ch_ready) |=> (ch_valid && $stable(ch_data)));

  a_pulse_excl: assert property (@(posedge clk)
    !(done && (err || ch_valid)));

endmodule

// File: tb/tb_text_line_streamer.sv
// Directed bench for text_line_streamer with registered mapper and ROM models
// and a negedge stream monitor.
module tb_text_line_streamer;
  localparam int ADDR_W = 10;
  localparam int LINE_W = 8;

  logic                clk       = 1'b0;
  logic                rst_n     = 1'b0;
  logic                req_valid = 1'b0;
  logic [LINE_W-1:0]   req_line  = '0;
  logic                ch_ready  = 1'b1;
  logic [2*ADDR_W-1:0] map_addr  = '0;
  logic [15:0]         rom_dout  = '0;
  logic                req_ready;
  logic [LINE_W-1:0]   map_line;
  logic [ADDR_W-1:0]   rom_addr;
  logic                ch_valid;
  logic [7:0]          ch_data;
  logic                ch_last;
  logic                done;
  logic                err;

  always #5 clk = ~clk;

  text_line_streamer #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_line  (req_line),
    .map_line  (map_line),
    .map_addr  (map_addr),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .ch_data   (ch_data),
    .ch_last   (ch_last),
    .done      (done),
    .err       (err)
  );

  function automatic logic [2*ADDR_W-1:0] map_lookup(input logic [LINE_W-1:0] l);
    case (l)
      8'd0:    return {10'd3, 10'd0};
      8'd1:    return {10'd5, 10'd5};
      8'd2:    return {10'd2, 10'd7};
      8'd3:    return {10'd1023, 10'd1023};
      8'd7:    return {10'd1, 10'd0};
      default: return '0;
    endcase
  endfunction

  // Words 4 and 6 are poison values that only show up if a range is overrun.
  function automatic logic [15:0] rom_lookup(input logic [ADDR_W-1:0] a);
    case (a)
      10'd0:    return 16'h3131;
      10'd1:    return 16'h4142;
      10'd2:    return 16'h7320;
      10'd3:    return 16'h2020;
      10'd4:    return 16'hBBBB;
      10'd5:    return 16'h3174;
      10'd6:    return 16'hEEEE;
      10'd1023: return 16'h5A21;
      default:  return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    map_addr <= map_lookup(map_line);
    rom_dout <= rom_lookup(rom_addr);
  end

  logic       bp_mode = 1'b0;
  logic [3:0] bp_pat  = 4'b1001;
  int         bp_idx  = 0;
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      ch_ready = bp_pat[bp_idx % 4];
      bp_idx++;
    end else begin
      ch_ready = 1'b1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int         cyc = 0;
  int         n_tot = 0;
  int         done_tot = 0;
  int         err_tot = 0;
  int         valid_tot = 0;
  int         stall_tot = 0;
  int         last_hs_cyc = 0;
  int         done_cyc = 0;
  logic [7:0] got [256];
  logic       got_last [256];
  logic       prev_stall = 1'b0;
  logic       prev_rst = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (prev_stall && prev_rst) begin
      check("stall_hold_valid", ch_valid, 1);
      check("stall_hold_data", ch_data, prev_data);
    end
    if (ch_valid) valid_tot++;
    if (ch_valid && !ch_ready) stall_tot++;
    if (ch_valid && ch_ready && rst_n) begin
      if (n_tot < 256) begin
        got[n_tot]      = ch_data;
        got_last[n_tot] = ch_last;
      end
      n_tot++;
      last_hs_cyc = cyc;
    end
    if (done) begin
      done_tot++;
      done_cyc = cyc;
    end
    if (err) err_tot++;
    if (done || err) check("pulse_excl", {29'd0, done & err, done & ch_valid, err & ch_valid}, 0);
    prev_stall = ch_valid && !ch_ready;
    prev_data  = ch_data;
    prev_rst   = rst_n;
  end

  task automatic request(input logic [LINE_W-1:0] l);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_line  = l;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0, input string tag);
    int k = 0;
    while (done_tot == d0 && err_tot == e0 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= 200) check({tag, "_timeout"}, 1, 0);
  endtask

  task automatic check_stream(input string tag, input int base, input int n, input logic [7:0] e [8]);
    check({tag, "_count"}, n_tot - base, n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", tag, i), got[base + i], e[i]);
      check($sformatf("%s_last%0d", tag, i), got_last[base + i], (i == n - 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_map_line"}, map_line, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_ch_valid"}, ch_valid, 0);
    check({tag, "_ch_data"}, ch_data, 0);
    check({tag, "_ch_last"}, ch_last, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  logic [7:0] exp_l0 [8] = '{8'h31, 8'h31, 8'h41, 8'h42, 8'h73, 8'h20, 8'h20, 8'h20};
  logic [7:0] exp_l1 [8] = '{8'h31, 8'h74, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp_l3 [8] = '{8'h5A, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    int  d0;
    int  e0;
    int  v0;
    int  s0;
    int  k;
    logic found;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Line 0 at full throughput, including first-byte latency.
    base = n_tot; d0 = done_tot; e0 = err_tot;
    request(8'd0);
    check("t1_busy", req_ready, 0);
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk); #1;
      if (j < 4) check($sformatf("t1_lat_e%0d", j), ch_valid, 0);
    end
    check("t1_first_valid", ch_valid, 1);
    check("t1_first_data", ch_data, 8'h31);
    wait_end(d0, e0, "t1");
    check("t1_done_after_last", done_cyc - last_hs_cyc, 1);
    @(posedge clk); #1;
    check("t1_done_width", done, 0);
    check("t1_idle", req_ready, 1);
    check_stream("t1", base, 8, exp_l0);
    check("t1_done_cnt", done_tot - d0, 1);
    check("t1_err_cnt", err_tot - e0, 0);
    check("t1_rom_addr", rom_addr, 3);

    // Single-word line.
    base = n_tot; d0 = done_tot; e0 = err_tot;
    request(8'd1);
    wait_end(d0, e0, "t2");
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    check_stream("t2", base, 2, exp_l1);
    check("t2_done_cnt", done_tot - d0, 1);
    check("t2_rom_addr", rom_addr, 5);

    // Backpressure with ch_ready cycling 1-0-0-1.
    base = n_tot; d0 = done_tot; e0 = err_tot; s0 = stall_tot;
    bp_mode = 1'b1;
    request(8'd0);
    wait_end(d0, e0, "t3");
    bp_mode = 1'b0;
    @(posedge clk); #1;
    check_stream("t3", base, 8, exp_l0);
    check("t3_stalls_seen", (stall_tot - s0) > 0, 1);
    check("t3_done_cnt", done_tot - d0, 1);

    // Inverted range is rejected.
    base = n_tot; d0 = done_tot; e0 = err_tot; v0 = valid_tot;
    request(8'd2);
    check("t4_err_e0", err, 0);
    @(posedge clk); #1;
    check("t4_err_e1", err, 0);
    check("t4_busy_e1", req_ready, 0);
    @(posedge clk); #1;
    check("t4_err_e2", err, 1);
    check("t4_ready_e2", req_ready, 1);
    @(posedge clk); #1;
    check("t4_err_e3", err, 0);
    repeat (4) @(posedge clk);
    #1;
    check("t4_err_cnt", err_tot - e0, 1);
    check("t4_no_valid", valid_tot - v0, 0);
    check("t4_no_done", done_tot - d0, 0);
    check("t4_rom_addr", rom_addr, 3);

    // Top-of-ROM single word: no wrap of rom_addr.
    base = n_tot; d0 = done_tot; e0 = err_tot;
    request(8'd3);
    wait_end(d0, e0, "t7");
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    check_stream("t7", base, 2, exp_l3);
    check("t7_rom_addr", rom_addr, 1023);
    check("t7_done_cnt", done_tot - d0, 1);

    // Request pulsed mid-stream is ignored.
    base = n_tot; d0 = done_tot; e0 = err_tot;
    request(8'd0);
    repeat (6) @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_line  = 8'd7;
    check("t6_busy", req_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("t6_map_line_mid", map_line, 0);
    wait_end(d0, e0, "t6");
    @(posedge clk); #1;
    check_stream("t6", base, 8, exp_l0);
    check("t6_map_line_end", map_line, 0);
    check("t6_done_cnt", done_tot - d0, 1);

    // Reset while the third word's high byte is on the stream.
    base = n_tot; d0 = done_tot; e0 = err_tot;
    request(8'd0);
    found = 1'b0;
    k = 0;
    while (!found && k < 100) begin
      @(posedge clk); #1;
      if (ch_valid && ch_data == 8'h73) found = 1'b1;
      k++;
    end
    if (!found) check("t5_find_hi_timeout", 1, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_outputs("t5");
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_done", done_tot - d0, 0);
    check("t5_bytes_before_rst", n_tot - base, 4);
    base = n_tot; d0 = done_tot; e0 = err_tot;
    request(8'd1);
    wait_end(d0, e0, "t5b");
    @(posedge clk); #1;
    check_stream("t5b", base, 2, exp_l1);
    check("t5b_done_cnt", done_tot - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
